// File: rtl/barrier_multi.sv
// -----------------------------------------------------------------------------
// barrier_multi
//
// Multi-ID barrier unit on the core's ring interface. The local core enters a
// barrier on one of 2**BID_W IDs. The unit waits for the ring token and puts
// one Barrier slot carrying that ID on the ring. It then releases the core with
// a one-cycle done pulse after it has observed every participant's slot for
// that ID, including its own slot when that slot comes back around the ring.
//
// Each ID has its own arrival counter. A counter wraps to zero when it
// reaches the participant target, and that wrap is the completion event.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   selBarrier, barrierId core request to enter barrier (sampled in idle)
//   nParticipants         participant count, quasi-static (0 treated as 1)
//   whichCore             local core number, used as the slot source
//   done                  one-cycle pulse: barrier complete
//   busy                  high while waiting for the token or the barrier
//   error                 sticky: Barrier slot seen with upper RingIn bits set
//   RingIn/SlotTypeIn/SourceIn              incoming ring slot
//   barrierRingOut/SlotTypeOut/SourceOut    outgoing Barrier slot
//   barrierDriveRing      drive the ring this cycle
//   barrierWantsToken     token request
//   barrierAcquireToken   token granted
// -----------------------------------------------------------------------------
module barrier_multi #(
    parameter int          BID_W        = 2,
    parameter int          CNT_W        = 5,
    parameter logic [3:0]  BARRIER_TYPE = 4'h7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             selBarrier,
    input  logic [BID_W-1:0] barrierId,
    input  logic [CNT_W-1:0] nParticipants,
    input  logic [3:0]       whichCore,
    output logic             done,
    output logic             busy,
    output logic             error,
    input  logic [31:0]      RingIn,
    input  logic [3:0]       SlotTypeIn,
    input  logic [3:0]       SourceIn,
    output logic [31:0]      barrierRingOut,
    output logic [3:0]       barrierSlotTypeOut,
    output logic [3:0]       barrierSourceOut,
    output logic             barrierDriveRing,
    output logic             barrierWantsToken,
    input  logic             barrierAcquireToken
);

    localparam int NBARRIERS = 2**BID_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TOKEN,
        WAIT_BARRIER
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BID_W-1:0] pending_id;
    logic [CNT_W-1:0] count [NBARRIERS];

    logic [CNT_W-1:0] target;
    logic             arrive;
    logic [BID_W-1:0] aid;
    logic             id_bad;
    logic             last;
    logic             complete;
    logic             pending_hit;

    // Slots are counted regardless of which core sent them, so the source
    // field of incoming slots is not needed.
    logic unused_source;
    assign unused_source = ^SourceIn;

    // -------------------------------------------------------------------------
    // Arrival decode
    // -------------------------------------------------------------------------
    assign target      = (nParticipants == '0) ? CNT_W'(1) : nParticipants;
    assign arrive      = (SlotTypeIn == BARRIER_TYPE);
    assign aid         = RingIn[BID_W-1:0];
    assign id_bad      = |RingIn[31:BID_W];
    assign last        = (count[aid] == target - CNT_W'(1));
    assign complete    = arrive && !id_bad && last;
    assign pending_hit = complete && (aid == pending_id);

    // -------------------------------------------------------------------------
    // Per-ID arrival counters
    // -------------------------------------------------------------------------
    // NOTE: this counter array sits in flops rather than RAM, because every
    // entry must be cleared on reset. A reset loop over a memory would not map
    // onto a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBARRIERS; i++) begin
                count[i] <= '0;
            end
        end else if (arrive && !id_bad) begin
            count[aid] <= last ? '0 : count[aid] + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register and registered side outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge, whatever the statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending_id <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_next;
            // Accepting only in idle keeps the ID on the ring stable while busy.
            if (state == IDLE && selBarrier) begin
                pending_id <= barrierId;
            end
            // A completion seen before the own slot is on the ring resets the
            // counter but must not release the core.
            done <= (state == WAIT_BARRIER) && pending_hit;
            if (arrive && id_bad) begin
                error <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets its default value first. Then no
    // path leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:         if (selBarrier)          state_next = WAIT_TOKEN;
            WAIT_TOKEN:   if (barrierAcquireToken) state_next = WAIT_BARRIER;
            WAIT_BARRIER: if (pending_hit)         state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Ring outputs
    // -------------------------------------------------------------------------
    // These are decoded straight from the state, so an asynchronous reset
    // drops them at once.
    assign busy               = (state != IDLE);
    assign barrierWantsToken  = (state == WAIT_TOKEN);
    // The own slot is on the ring only in the grant cycle.
    assign barrierDriveRing   = (state == WAIT_TOKEN) && barrierAcquireToken;
    assign barrierRingOut     = {{(32-BID_W){1'b0}}, pending_id};
    assign barrierSlotTypeOut = BARRIER_TYPE;
    assign barrierSourceOut   = whichCore;

endmodule

// File: tb/tb_barrier_multi.sv
// -----------------------------------------------------------------------------
// tb_barrier_multi
//
// Directed bench for barrier_multi. A behavioural model tracks arrivals per ID
// as plain integers, together with what the core is waiting for. A compare
// process checks every DUT output against the model on each falling edge.
// Literal expectations at the key points of each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_barrier_multi;

    localparam int         BID_W = 2;
    localparam int         CNT_W = 5;
    localparam logic [3:0] BT    = 4'h7;

    logic             clock;
    logic             reset;
    logic             selBarrier;
    logic [BID_W-1:0] barrierId;
    logic [CNT_W-1:0] nParticipants;
    logic [3:0]       whichCore;
    logic             done;
    logic             busy;
    logic             error;
    logic [31:0]      RingIn;
    logic [3:0]       SlotTypeIn;
    logic [3:0]       SourceIn;
    logic [31:0]      barrierRingOut;
    logic [3:0]       barrierSlotTypeOut;
    logic [3:0]       barrierSourceOut;
    logic             barrierDriveRing;
    logic             barrierWantsToken;
    logic             barrierAcquireToken;

    int total = 0;
    int bad   = 0;

    barrier_multi #(.BID_W(BID_W), .CNT_W(CNT_W), .BARRIER_TYPE(BT)) dut (
        .clock               (clock),
        .reset               (reset),
        .selBarrier          (selBarrier),
        .barrierId           (barrierId),
        .nParticipants       (nParticipants),
        .whichCore           (whichCore),
        .done                (done),
        .busy                (busy),
        .error               (error),
        .RingIn              (RingIn),
        .SlotTypeIn          (SlotTypeIn),
        .SourceIn            (SourceIn),
        .barrierRingOut      (barrierRingOut),
        .barrierSlotTypeOut  (barrierSlotTypeOut),
        .barrierSourceOut    (barrierSourceOut),
        .barrierDriveRing    (barrierDriveRing),
        .barrierWantsToken   (barrierWantsToken),
        .barrierAcquireToken (barrierAcquireToken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // mode: 0 = free, 1 = wants the token, 2 = own slot sent, awaiting others
    // -------------------------------------------------------------------------
    int         m_cnt [4];
    int         m_mode;
    logic [1:0] m_pid;
    bit         m_done;
    bit         m_err;
    int         m_tgt;
    int         m_aid;
    bit         m_comp;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_mode = 0;
            m_pid  = 2'd0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_comp = 1'b0;
            m_aid  = int'(RingIn[1:0]);
            m_tgt  = (nParticipants == 0) ? 1 : int'(nParticipants);
            if (SlotTypeIn == BT) begin
                if (RingIn[31:2] != 30'd0) begin
                    m_err = 1'b1;
                end else if (m_cnt[m_aid] + 1 == m_tgt) begin
                    m_cnt[m_aid] = 0;
                    m_comp       = 1'b1;
                end else begin
                    m_cnt[m_aid] = m_cnt[m_aid] + 1;
                end
            end
            m_done = (m_mode == 2) && m_comp && (m_aid == int'(m_pid));
            if (m_mode == 0 && selBarrier) begin
                m_pid  = barrierId;
                m_mode = 1;
            end else if (m_mode == 1 && barrierAcquireToken) begin
                m_mode = 2;
            end else if (m_done) begin
                m_mode = 0;
            end
        end
    end

    always @(negedge clock) begin
        check("done",      32'(done),               32'(m_done));
        check("busy",      32'(busy),               32'(m_mode != 0));
        check("error",     32'(error),              32'(m_err));
        check("wants",     32'(barrierWantsToken),  32'(m_mode == 1));
        check("drive",     32'(barrierDriveRing),   32'(m_mode == 1 && barrierAcquireToken));
        check("ring_out",  barrierRingOut,          32'(m_pid));
        check("slot_type", 32'(barrierSlotTypeOut), 32'(BT));
        check("source",    32'(barrierSourceOut),   32'(whichCore));
    end

    // One clock cycle of stimulus. It is entered and left 2 time units after a rising edge.
    task automatic cyc(input bit sel, input logic [1:0] bid, input bit slot,
                       input logic [31:0] ring, input bit acq);
        selBarrier          = sel;
        barrierId           = bid;
        SlotTypeIn          = slot ? BT : 4'h2;
        RingIn              = ring;
        barrierAcquireToken = acq;
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic slot_id(input logic [1:0] id);
        cyc(1'b0, 2'd0, 1'b1, {30'd0, id}, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b0;
        selBarrier          = 1'b0;
        barrierId           = '0;
        nParticipants       = 5'd4;
        whichCore           = 4'd3;
        RingIn              = '0;
        SlotTypeIn          = 4'h0;
        SourceIn            = 4'h5;
        barrierAcquireToken = 1'b0;
        #1;
        check("rst_done",  32'(done), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wants", 32'(barrierWantsToken), 32'd0);
        check("rst_drive", 32'(barrierDriveRing), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        idle();

        // 1: four participants on ID 1, three foreign slots arrive first.
        nParticipants = 5'd4;
        cyc(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ring", barrierRingOut, 32'd1);
        slot_id(2'd1);
        slot_id(2'd1);
        slot_id(2'd1);
        check("t1_done_early", 32'(done), 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        idle();
        slot_id(2'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        idle();
        check("t1_done_once", 32'(done), 32'd0);

        // 2: three participants on ID 2, with ID 0 traffic interleaved.
        nParticipants = 5'd3;
        cyc(1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        slot_id(2'd0);
        slot_id(2'd2);
        slot_id(2'd0);
        slot_id(2'd2);
        slot_id(2'd0);
        check("t2_done_early", 32'(done), 32'd0);
        slot_id(2'd2);
        check("t2_done", 32'(done), 32'd1);
        idle();

        // 3: a participant count of zero means the own slot alone completes.
        nParticipants = 5'd0;
        cyc(1'b1, 2'd3, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        idle();
        check("t3_wait", 32'(done), 32'd0);
        slot_id(2'd3);
        check("t3_done", 32'(done), 32'd1);
        idle();

        // 4: a re-request while busy is ignored; a request in the done cycle is accepted.
        nParticipants = 5'd2;
        cyc(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        check("t4_ring_kept", barrierRingOut, 32'd1);
        check("t4_no_drive", 32'(barrierDriveRing), 32'd0);
        slot_id(2'd1);
        slot_id(2'd1);
        check("t4_done", 32'(done), 32'd1);
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
        check("t4_reaccept_busy", 32'(busy), 32'd1);
        check("t4_reaccept_ring", barrierRingOut, 32'd0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        slot_id(2'd0);
        slot_id(2'd0);
        check("t4_done2", 32'(done), 32'd1);
        idle();

        // 5: a malformed Barrier slot sets the sticky error and is not counted.
        nParticipants = 5'd2;
        cyc(1'b0, 2'd0, 1'b1, 32'h100, 1'b0);
        check("t5_error", 32'(error), 32'd1);
        idle();
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        slot_id(2'd0);
        check("t5_no_count", 32'(done), 32'd0);
        slot_id(2'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_error_sticky", 32'(error), 32'd1);
        idle();

        // 6: asynchronous reset while waiting for the token, with count[3]=2.
        nParticipants = 5'd4;
        slot_id(2'd3);
        slot_id(2'd3);
        cyc(1'b1, 2'd3, 1'b0, 32'h0, 1'b0);
        SlotTypeIn          = 4'h2;
        selBarrier          = 1'b0;
        barrierAcquireToken = 1'b1;
        #1;
        check("t6_drive_pre", 32'(barrierDriveRing), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_wants", 32'(barrierWantsToken), 32'd0);
        check("t6_drive", 32'(barrierDriveRing), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        check("t6_done",  32'(done), 32'd0);
        check("t6_ring",  barrierRingOut, 32'd0);
        barrierAcquireToken = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        cyc(1'b1, 2'd3, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        slot_id(2'd3);
        slot_id(2'd3);
        slot_id(2'd3);
        check("t6_cleared", 32'(done), 32'd0);
        slot_id(2'd3);
        check("t6_done_after", 32'(done), 32'd1);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrier_multi.md
Name: barrier_multi

Overview:
- Parametrised successor to the single-barrier ring unit.
- Supports 2**BID_W independent barrier IDs and a run-time participant count.
- The local core enters a barrier on a chosen ID. The unit broadcasts a Barrier slot carrying that ID on the ring and releases the core when every participant's slot for that ID has been observed.
- Sits beside the other local I/O devices on the core's ring interface.

Parameters:
- BID_W, 2: barrier-ID width. NBARRIERS = 2**BID_W per-ID counters.
- CNT_W, 5: participant-counter width. Maximum participants = 2**CNT_W - 1.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- selBarrier  in  1  core request to enter barrier. Sampled only in idle.
- barrierId  in  BID_W  barrier ID, sampled with selBarrier
- nParticipants  in  CNT_W  cores taking part, quasi-static. 0 is treated as 1.
- whichCore  in  4  local core number
- done  out  1  one-cycle pulse: barrier complete, core may proceed
- busy  out  1  high in waitToken and waitBarrier
- error  out  1  sticky. Set when an arriving Barrier slot carries nonzero RingIn[31:BID_W]. Cleared only by reset.
- RingIn  in  32  ring data
- SlotTypeIn  in  4  ring slot type
- SourceIn  in  4  ring slot source
- barrierRingOut  out  32  {zeros, pendingId}
- barrierSlotTypeOut  out  4  constant `Barrier
- barrierSourceOut  out  4  whichCore
- barrierDriveRing  out  1  drive ring this cycle
- barrierWantsToken  out  1  token request
- barrierAcquireToken  in  1  token granted

Behaviour:
- Reset (reset=0, async):
  - state=idle; all counters=0; pendingId=0.
  - done=0, busy=0, error=0, barrierWantsToken=0, barrierDriveRing=0.
- Definitions:
  - target = (nParticipants==0) ? 1 : nParticipants.
  - arrive = (SlotTypeIn==`Barrier).
  - aid = RingIn[BID_W-1:0].
- Arrival counting (all states):
  - On arrive, when RingIn[31:BID_W] is nonzero: set error; counters unchanged.
  - Otherwise, when count[aid]==target-1: count[aid] <= 0 and a completion for aid occurs.
  - Otherwise: count[aid] <= count[aid]+1.
  - Counters for other IDs are unaffected.
  - The unit's own slot is counted when it returns around the ring, like any other.
- FSM:
  - idle: on selBarrier, latch pendingId <= barrierId and go to waitToken.
  - waitToken:
    - barrierWantsToken=1.
    - barrierDriveRing = barrierAcquireToken (combinational).
    - On barrierAcquireToken, go to waitBarrier.
  - waitBarrier: on a completion for aid==pendingId, go to idle and assert done for exactly one cycle (registered, cycle after the completing slot).
- Completion rules outside waitBarrier:
  - A completion for pendingId observed in idle or waitToken resets the counter only and gives no done. This indicates a misconfigured nParticipants.
  - The local slot will then count toward the next generation.
- Request rules:
  - selBarrier while busy is ignored; barrierId/pendingId do not change.
  - selBarrier in the same cycle done pulses, with state already idle, is accepted.
- Simultaneous events: the arrival in the cycle the token is acquired is counted normally. The own slot is on the ring only in that cycle and returns later.
- Wrap-around: counters never exceed target-1. A change of nParticipants mid-barrier is unsupported: behaviour is defined only for counts below the new target.
- Reset mid-operation returns to idle with all counters cleared. Ring outputs deassert immediately.

Test Plan:
- nParticipants=4, core requests ID 1; three foreign ID-1 slots arrive, token granted, own slot returns -> done pulses once, one cycle after the 4th ID-1 slot; count[1]=0, busy=0.
- ID 0 and ID 2 slots interleaved while waiting on ID 2 (nParticipants=3) -> count[0] advances independently; done only after the 3rd ID-2 slot.
- nParticipants=0 -> own slot alone completes; done one cycle after its return.
- selBarrier pulsed again while in waitBarrier with a different ID -> ignored; barrierRingOut still shows the original ID; only one slot is driven.
- Barrier slot with RingIn=32'h100 arrives -> error=1 and stays set; no counter changes.
- reset asserted asynchronously in waitToken with count[3]=2 -> all outputs 0 immediately; count[3]=0 after release.
